// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: drains the holding register via the read strobe
// into a show-ahead FIFO of {overrun, framingerr, parityerr, data} entries with a pop port.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned THRESH = 8
) (
  input  logic          mclkx16,
  input  logic          reset_n,
  input  logic [7:0]    rdata,
  input  logic          rxrdy,
  input  logic          parityerr,
  input  logic          framingerr,
  input  logic          overrun,
  output logic          read,
  output logic [10:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          full,
  output logic          rx_irq,
  output logic [7:0]    err_cnt
);

  localparam logic [AW:0]   DepthCnt  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ThreshCnt = (AW + 1)'(THRESH);
  localparam logic [AW:0]   CntOne    = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e        state_q;
  logic          read_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [10:0]   mem_q [DEPTH];
  logic [10:0]   wdata;
  logic          push, pop;

  assign full       = (count_q == DepthCnt);
  assign dout_valid = (count_q != '0);
  assign rx_irq     = (count_q >= ThreshCnt);
  assign count      = count_q;
  assign err_cnt    = err_cnt_q;
  assign read       = read_q;
  assign dout       = mem_q[rd_ptr_q];

  // Capture happens in IDLE, before read rises and the receiver blanks rdata.
  assign wdata = {overrun, framingerr, parityerr, rdata};
  assign push  = (state_q == StIdle) && rxrdy && !full;
  assign pop   = dout_valid && dout_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop)      count_d = count_q + CntOne;
      else if (!push && pop) count_d = count_q - CntOne;
      if (push && (wdata[10:8] != 3'b000) && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge mclkx16) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge mclkx16) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  // WAIT holds off until rxrdy drops so a stale holding register is not captured twice.
  always_ff @(posedge mclkx16) begin
    if (!reset_n) begin
      state_q <= StIdle;
      read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rxrdy && !full) begin
            read_q  <= 1'b1;
            state_q <= StAck;
          end else begin
            read_q  <= 1'b0;
          end
        end
        StAck: begin
          read_q  <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          read_q <= 1'b0;
          if (!rxrdy) state_q <= StIdle;
        end
        default: begin
          read_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a small receiver-holding-register model driving it.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rdata;
  logic        rxrdy;
  logic        read;
  logic [10:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        flush;
  logic [4:0]  count;
  logic        full;
  logic        rx_irq;
  logic [7:0]  err_cnt;

  logic [7:0]  rx_data;
  logic        rx_pe, rx_fe, rx_ov;
  logic        ld_req;
  logic [7:0]  ld_data;
  logic        ld_pe, ld_fe;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;
  logic [10:0] q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .THRESH(8)) dut (
    .mclkx16    (clk),
    .reset_n    (reset_n),
    .rdata      (rdata),
    .rxrdy      (rxrdy),
    .parityerr  (rx_pe),
    .framingerr (rx_fe),
    .overrun    (rx_ov),
    .read       (read),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .flush      (flush),
    .count      (count),
    .full       (full),
    .rx_irq     (rx_irq),
    .err_cnt    (err_cnt)
  );

  // Receiver model: a byte arriving while one is still held keeps the held byte and flags overrun.
  assign rdata = read ? 8'h00 : rx_data;
  always @(posedge clk) begin
    if (!reset_n) begin
      rxrdy   <= 1'b0;
      rx_data <= 8'h00;
      rx_pe   <= 1'b0;
      rx_fe   <= 1'b0;
      rx_ov   <= 1'b0;
    end else if (ld_req) begin
      if (rxrdy) begin
        rx_ov <= 1'b1;
      end else begin
        rx_data <= ld_data;
        rx_pe   <= ld_pe;
        rx_fe   <= ld_fe;
        rx_ov   <= 1'b0;
      end
      rxrdy <= 1'b1;
    end else if (read) begin
      rxrdy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] b, input logic pe, input logic fe);
    @(negedge clk);
    ld_req  = 1'b1;
    ld_data = b;
    ld_pe   = pe;
    ld_fe   = fe;
    @(negedge clk);
    ld_req  = 1'b0;
  endtask

  // Waits (bounded) for the receiver to be acknowledged, counting read-high cycles.
  task automatic drain();
    pulses = 0;
    for (int n = 0; n < 40 && rxrdy; n++) begin
      @(negedge clk);
      if (read) pulses++;
    end
    check("drain_rxrdy_clear", 32'(rxrdy), 32'd0);
    @(negedge clk);
    if (read) pulses++;
  endtask

  task automatic send(input logic [7:0] b, input logic pe, input logic fe);
    load(b, pe, fe);
    drain();
  endtask

  task automatic pop_one();
    @(negedge clk);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    ld_req     = 1'b0;
    ld_data    = 8'h00;
    ld_pe      = 1'b0;
    ld_fe      = 1'b0;
    dout_ready = 1'b0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read", 32'(read), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_irq", 32'(rx_irq), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single byte
    send(8'hA5, 1'b0, 1'b0);
    check("single_read_pulse", 32'(pulses), 32'd1);
    check("single_dout", 32'(dout), 32'h0A5);
    check("single_valid", 32'(dout_valid), 32'd1);
    check("single_count", 32'(count), 32'd1);
    pop_one();
    check("single_pop_valid", 32'(dout_valid), 32'd0);
    check("single_pop_count", 32'(count), 32'd0);

    // Error tagging
    send(8'h3C, 1'b1, 1'b0);
    send(8'h81, 1'b0, 1'b1);
    check("err_dout0", 32'(dout), 32'h13C);
    pop_one();
    check("err_dout1", 32'(dout), 32'h281);
    check("err_cnt2", 32'(err_cnt), 32'd2);
    pop_one();
    check("err_empty", 32'(dout_valid), 32'd0);

    // Fill and stall
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, 1'b0);
      check("fill_irq", 32'(rx_irq), 32'((i + 1) >= 8));
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("fill_full", 32'(full), 32'd1);
    load(8'h10, 1'b0, 1'b0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (read) pulses++;
    end
    load(8'h11, 1'b0, 1'b0);
    repeat (6) begin
      @(negedge clk);
      if (read) pulses++;
    end
    check("stall_no_read", 32'(pulses), 32'd0);
    check("stall_rxrdy_held", 32'(rxrdy), 32'd1);
    check("stall_head", 32'(dout), 32'h000);
    pop_one();
    drain();
    check("refill_count", 32'(count), 32'd16);
    check("refill_full", 32'(full), 32'd1);
    check("ovr_err_cnt", 32'(err_cnt), 32'd3);
    for (int i = 1; i < 16; i++) begin
      check("fill_order", 32'(dout), 32'(i));
      pop_one();
    end
    check("ovr_entry", 32'(dout), 32'h410);
    pop_one();
    check("fill_empty", 32'(dout_valid), 32'd0);

    // Simultaneous push and pop at count 5, crossing the pointer wrap
    q.delete();
    for (int i = 0; i < 5; i++) begin
      send(8'h50 + 8'(i), 1'b0, 1'b0);
      q.push_back(11'h050 + 11'(i));
    end
    check("pp_count_init", 32'(count), 32'd5);
    for (int k = 0; k < 14; k++) begin
      load(8'h60 + 8'(k), 1'b0, 1'b0);
      check("pp_head", 32'(dout), 32'(q[0]));
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      void'(q.pop_front());
      q.push_back(11'h060 + 11'(k));
      check("pp_count", 32'(count), 32'd5);
      check("pp_read", 32'(read), 32'd1);
      drain();
    end
    for (int i = 0; i < 5; i++) begin
      check("pp_order", 32'(dout), 32'(q[0]));
      void'(q.pop_front());
      pop_one();
    end
    check("pp_empty", 32'(dout_valid), 32'd0);

    // Flush in the push cycle
    load(8'h77, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_err", 32'(err_cnt), 32'd0);
    check("flush_read", 32'(read), 32'd1);
    drain();
    check("flush_lost", 32'(dout_valid), 32'd0);
    send(8'h42, 1'b0, 1'b0);
    check("flush_after_dout", 32'(dout), 32'h042);
    check("flush_after_count", 32'(count), 32'd1);
    pop_one();

    // Reset mid-handshake
    load(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_read_high", 32'(read), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_read_low", 32'(read), 32'd0);
    check("mid_count", 32'(count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'hC3, 1'b0, 1'b0);
    check("mid_pulse", 32'(pulses), 32'd1);
    check("mid_dout", 32'(dout), 32'h0C3);
    repeat (5) @(negedge clk);
    check("mid_count_once", 32'(count), 32'd1);
    pop_one();
    check("mid_empty", 32'(dout_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
